lz77_encoder: RTL

- Streaming LZ77 encoder that produces (code_pos, code_len, char_nxt) triples for the team's LZ77 decoder.
- Geometry matches the decoder exactly: 9-entry search buffer, 8-entry look-ahead, match length 0..7, terminator '$' (8'h24).
- Sits between a byte source (valid/ready) and the code sink (valid/ready). A decoder fed its triples reproduces the input byte stream.

---
 rtl/lz77_pkg.sv | 30 +++
 rtl/lz77_match_len.sv | 61 ++++++
 rtl/lz77_encoder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lz77_pkg.sv
// lz77_pkg: shared geometry, field widths and FSM state type for the LZ77 encoder
// and its matching decoder.
//
// Contents:
//   SEARCH_DEPTH, LOOKAHEAD, MAX_LEN  buffer geometry (MAX_LEN = LOOKAHEAD-1)
//   TERM_CHAR                         end-of-stream byte ('$')
//   POS_W, LEN_W                      triple field widths
//   CNT_W, LA_IDX_W                   buffer fill-count and look-ahead index widths
//   lz77_state_e                      encoder FSM states
package lz77_pkg;

   localparam int unsigned SEARCH_DEPTH = 9;
   localparam int unsigned LOOKAHEAD    = 8;
   localparam int unsigned MAX_LEN      = LOOKAHEAD - 1;
   localparam logic [7:0]  TERM_CHAR    = 8'h24;

   localparam int unsigned POS_W    = 4;
   localparam int unsigned LEN_W    = 3;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned LA_IDX_W = 3;

   typedef enum logic [2:0] {
      FILL,
      SCAN,
      EMIT,
      SHIFT,
      DONE
   } lz77_state_e;

endpackage

// File: rtl/lz77_match_len.sv
// lz77_match_len: combinational match length for one candidate search position.
//
// Ports:
//   search_buf  in   search buffer, entry 0 = most recent byte
//   la_buf      in   look-ahead buffer, entry 0 = next byte to encode
//   search_cnt  in   number of valid search entries
//   la_cnt      in   number of valid look-ahead entries
//   cand_pos    in   candidate position p (distance-1)
//   match_len   out  match length at p, capped at MAX_LEN and la_cnt-1; 0 if p ineligible
module lz77_match_len
   import lz77_pkg::*;
(
   input  logic [SEARCH_DEPTH-1:0][7:0] search_buf,
   input  logic [LOOKAHEAD-1:0][7:0]    la_buf,
   input  logic [CNT_W-1:0]             search_cnt,
   input  logic [CNT_W-1:0]             la_cnt,
   input  logic [POS_W-1:0]             cand_pos,
   output logic [LEN_W-1:0]             match_len
);

   logic [LEN_W-1:0] cap;
   logic [LEN_W-1:0] len;
   logic             run;
   logic [7:0]       win;

   always_comb begin
      cap = '0;
      len = '0;
      run = 1'b1;
      win = '0;

      // Keep at least one look-ahead byte for the literal.
      if (la_cnt > CNT_W'(MAX_LEN)) begin
         cap = LEN_W'(MAX_LEN);
      end else if (la_cnt != '0) begin
         cap = LEN_W'(la_cnt - 1'b1);
      end

      for (int i = 0; i < MAX_LEN; i++) begin
         // Once the window runs past the search buffer it continues into the
         // look-ahead itself, which is what allows overlapping matches.
         if (i <= int'(cand_pos)) begin
            win = search_buf[POS_W'(int'(cand_pos) - i)];
         end else begin
            win = la_buf[LA_IDX_W'(i - int'(cand_pos) - 1)];
         end
         if (run && (LEN_W'(i) < cap) && (la_buf[LA_IDX_W'(i)] == win) &&
             (la_buf[LA_IDX_W'(i)] != TERM_CHAR)) begin
            len = len + 1'b1;
         end else begin
            run = 1'b0;
         end
      end

      if (cand_pos >= search_cnt) begin
         len = '0;
      end
      match_len = len;
   end

endmodule

// File: rtl/lz77_encoder.sv
// lz77_encoder: streaming LZ77 encoder producing (code_pos, code_len, char_nxt)
// triples. Bytes enter a look-ahead buffer, one search position is evaluated per
// SCAN cycle, the best match is emitted, then L+1 bytes are shifted into the
// search buffer.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   chardata valid
//   in_ready   out  byte accepted this cycle when in_valid=1
//   chardata   in   input byte
//   out_valid  out  triple valid
//   out_ready  in   sink accepts triple
//   code_pos   out  match distance-1 (0 = most recent byte)
//   code_len   out  match length
//   char_nxt   out  literal following the match
//   encode     out  high once out of reset
//   finish     out  sticky, set when the TERM_CHAR triple is accepted
//   stat_codes out  accepted triples, saturating (LZ77_ENCODER_STATS_EN only)
//   stat_chars out  accepted bytes, saturating (LZ77_ENCODER_STATS_EN only)
//
// Build option: define LZ77_ENCODER_STATS_EN to add the statistics counters.
module lz77_encoder
   import lz77_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       chardata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] code_pos,
   output logic [LEN_W-1:0] code_len,
   output logic [7:0]       char_nxt,
   output logic             encode,
   output logic             finish
`ifdef LZ77_ENCODER_STATS_EN
   ,
   output logic [15:0]      stat_codes,
   output logic [15:0]      stat_chars
`endif
);

   lz77_state_e                  state_q, state_d;
   logic [SEARCH_DEPTH-1:0][7:0] search_q, search_d;
   logic [LOOKAHEAD-1:0][7:0]    la_q, la_d;
   logic [CNT_W-1:0]             search_cnt_q, search_cnt_d;
   logic [CNT_W-1:0]             la_cnt_q, la_cnt_d;
   logic                         term_seen_q, term_seen_d;
   logic [POS_W-1:0]             scan_p_q, scan_p_d;
   logic [LEN_W-1:0]             best_len_q, best_len_d;
   logic [POS_W-1:0]             best_pos_q, best_pos_d;
   logic [LEN_W:0]               shift_cnt_q, shift_cnt_d;
   logic                         in_ready_q, in_ready_d;
   logic                         out_valid_q, out_valid_d;
   logic [POS_W-1:0]             code_pos_q, code_pos_d;
   logic [LEN_W-1:0]             code_len_q, code_len_d;
   logic [7:0]                   char_nxt_q, char_nxt_d;
   logic                         encode_q, encode_d;
   logic                         finish_q, finish_d;

   logic [LEN_W-1:0] cand_len;
   logic [LEN_W-1:0] scan_len;
   logic [POS_W-1:0] scan_pos;
   logic             byte_accept;
   logic             code_accept;

   assign byte_accept = in_valid & in_ready_q;
   assign code_accept = out_valid_q & out_ready;

   lz77_match_len u_match_len (
      .search_buf (search_q),
      .la_buf     (la_q),
      .search_cnt (search_cnt_q),
      .la_cnt     (la_cnt_q),
      .cand_pos   (scan_p_q),
      .match_len  (cand_len)
   );

   always_comb begin
      state_d      = state_q;
      search_d     = search_q;
      la_d         = la_q;
      search_cnt_d = search_cnt_q;
      la_cnt_d     = la_cnt_q;
      term_seen_d  = term_seen_q;
      scan_p_d     = scan_p_q;
      best_len_d   = best_len_q;
      best_pos_d   = best_pos_q;
      shift_cnt_d  = shift_cnt_q;
      out_valid_d  = out_valid_q;
      code_pos_d   = code_pos_q;
      code_len_d   = code_len_q;
      char_nxt_d   = char_nxt_q;
      finish_d     = finish_q;
      encode_d     = 1'b1;
      scan_len     = best_len_q;
      scan_pos     = best_pos_q;

      unique case (state_q)
         FILL: begin
            if (term_seen_q || (la_cnt_q == CNT_W'(LOOKAHEAD))) begin
               state_d    = SCAN;
               scan_p_d   = '0;
               best_len_d = '0;
               best_pos_d = '0;
            end else if (byte_accept) begin
               la_d[la_cnt_q[LA_IDX_W-1:0]] = chardata;
               la_cnt_d = la_cnt_q + 1'b1;
               if (chardata == TERM_CHAR) begin
                  term_seen_d = 1'b1;
               end
               if ((chardata == TERM_CHAR) || (la_cnt_q == CNT_W'(LOOKAHEAD - 1))) begin
                  state_d    = SCAN;
                  scan_p_d   = '0;
                  best_len_d = '0;
                  best_pos_d = '0;
               end
            end
         end

         SCAN: begin
            // Strictly longer only, so the smallest p wins a tie.
            if (cand_len > best_len_q) begin
               scan_len = cand_len;
               scan_pos = scan_p_q;
            end
            best_len_d = scan_len;
            best_pos_d = scan_pos;
            if (scan_p_q == POS_W'(SEARCH_DEPTH - 1)) begin
               state_d     = EMIT;
               out_valid_d = 1'b1;
               code_pos_d  = scan_pos;
               code_len_d  = scan_len;
               char_nxt_d  = la_q[scan_len];
            end else begin
               scan_p_d = scan_p_q + 1'b1;
            end
         end

         EMIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (char_nxt_q == TERM_CHAR) begin
                  finish_d = 1'b1;
                  state_d  = DONE;
               end else begin
                  shift_cnt_d = {1'b0, code_len_q} + 1'b1;
                  state_d     = SHIFT;
               end
            end
         end

         SHIFT: begin
            search_d = {search_q[SEARCH_DEPTH-2:0], la_q[0]};
            la_d     = {8'h00, la_q[LOOKAHEAD-1:1]};
            la_cnt_d = la_cnt_q - 1'b1;
            if (search_cnt_q != CNT_W'(SEARCH_DEPTH)) begin
               search_cnt_d = search_cnt_q + 1'b1;
            end
            shift_cnt_d = shift_cnt_q - 1'b1;
            if (shift_cnt_q == (LEN_W + 1)'(1)) begin
               state_d = FILL;
            end
         end

         DONE: begin
            out_valid_d = 1'b0;
         end

         default: begin
            state_d = FILL;
         end
      endcase

      // Registered ready: only in FILL, with room and no terminator yet.
      in_ready_d = (state_d == FILL) && !term_seen_d && (la_cnt_d < CNT_W'(LOOKAHEAD));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FILL;
         search_q     <= '0;
         la_q         <= '0;
         search_cnt_q <= '0;
         la_cnt_q     <= '0;
         term_seen_q  <= 1'b0;
         scan_p_q     <= '0;
         best_len_q   <= '0;
         best_pos_q   <= '0;
         shift_cnt_q  <= '0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         code_pos_q   <= '0;
         code_len_q   <= '0;
         char_nxt_q   <= '0;
         encode_q     <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         search_q     <= search_d;
         la_q         <= la_d;
         search_cnt_q <= search_cnt_d;
         la_cnt_q     <= la_cnt_d;
         term_seen_q  <= term_seen_d;
         scan_p_q     <= scan_p_d;
         best_len_q   <= best_len_d;
         best_pos_q   <= best_pos_d;
         shift_cnt_q  <= shift_cnt_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         code_pos_q   <= code_pos_d;
         code_len_q   <= code_len_d;
         char_nxt_q   <= char_nxt_d;
         encode_q     <= encode_d;
         finish_q     <= finish_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign code_pos  = code_pos_q;
   assign code_len  = code_len_q;
   assign char_nxt  = char_nxt_q;
   assign encode    = encode_q;
   assign finish    = finish_q;

`ifdef LZ77_ENCODER_STATS_EN
   logic [15:0] stat_codes_q, stat_codes_d;
   logic [15:0] stat_chars_q, stat_chars_d;

   always_comb begin
      stat_codes_d = stat_codes_q;
      stat_chars_d = stat_chars_q;
      if (code_accept && (stat_codes_q != 16'hFFFF)) begin
         stat_codes_d = stat_codes_q + 16'd1;
      end
      if (byte_accept && (stat_chars_q != 16'hFFFF)) begin
         stat_chars_d = stat_chars_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_codes_q <= '0;
         stat_chars_q <= '0;
      end else begin
         stat_codes_q <= stat_codes_d;
         stat_chars_q <= stat_chars_d;
      end
   end

   assign stat_codes = stat_codes_q;
   assign stat_chars = stat_chars_q;
`else
   logic unused_code_accept;
   assign unused_code_accept = code_accept;
`endif

endmodule
